// File: rtl/vec_csr_pkg.sv
// Shared types and constants for the vector configuration CSR unit:
// instruction kinds, vsew/vlmul encodings, CSR addresses and FSM states.
package vec_csr_pkg;

   typedef enum logic [1:0] {
      CFG_VSETVLI  = 2'b00,
      CFG_VSETIVLI = 2'b01,
      CFG_VSETVL   = 2'b10,
      CFG_RSVD     = 2'b11
   } cfg_type_e;

   localparam logic [2:0] SEW_E8  = 3'd0;
   localparam logic [2:0] SEW_E16 = 3'd1;
   localparam logic [2:0] SEW_E32 = 3'd2;
   localparam logic [2:0] SEW_E64 = 3'd3;

   localparam logic [2:0] LMUL_M1   = 3'b000;
   localparam logic [2:0] LMUL_M2   = 3'b001;
   localparam logic [2:0] LMUL_M4   = 3'b010;
   localparam logic [2:0] LMUL_M8   = 3'b011;
   localparam logic [2:0] LMUL_RSVD = 3'b100;
   localparam logic [2:0] LMUL_MF8  = 3'b101;
   localparam logic [2:0] LMUL_MF4  = 3'b110;
   localparam logic [2:0] LMUL_MF2  = 3'b111;

   localparam logic [11:0] CSR_ADDR_VL     = 12'hC20;
   localparam logic [11:0] CSR_ADDR_VTYPE  = 12'hC21;
   localparam logic [11:0] CSR_ADDR_VLENB  = 12'hC22;
   localparam logic [11:0] CSR_ADDR_VSTART = 12'h008;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_e;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational VLMAX computation for a requested SEW/LMUL pair, plus the
// flag saying that pair cannot be supported with the configured ELEN.
module vec_vlmax_calc
   import vec_csr_pkg::*;
#(
   parameter int VLEN = 512,
   parameter int ELEN = 32,
   parameter int VW   = $clog2(VLEN) + 1
) (
   input  logic [2:0]    vsew,
   input  logic [2:0]    vlmul,
   output logic [VW-1:0] vlmax,
   output logic          illegal
);

   localparam int SEW_MAX = $clog2(ELEN / 8);

   logic [VW-1:0] base;
   logic [1:0]    k;

   always_comb begin
      base  = '0;
      k     = '0;
      vlmax = '0;
      case (vsew)
         SEW_E8:  base = VW'(VLEN / 8);
         SEW_E16: base = VW'(VLEN / 16);
         SEW_E32: base = VW'(VLEN / 32);
         SEW_E64: base = VW'(VLEN / 64);
         default: base = '0;
      endcase
      case (vlmul)
         LMUL_M1:  vlmax = base;
         LMUL_M2:  vlmax = base << 1;
         LMUL_M4:  vlmax = base << 2;
         LMUL_M8:  vlmax = base << 3;
         LMUL_MF2: begin k = 2'd1; vlmax = base >> 1; end
         LMUL_MF4: begin k = 2'd2; vlmax = base >> 2; end
         LMUL_MF8: begin k = 2'd3; vlmax = base >> 3; end
         default:  vlmax = '0;
      endcase
      // k is zero for integer LMUL, so this one test also covers SEW > ELEN
      illegal = (vlmul == LMUL_RSVD) || ((int'(vsew) + int'(k)) > SEW_MAX);
   end

endmodule

// File: rtl/vec_csr_cfg.sv
// Vector configuration CSR unit: executes vsetvli/vsetivli/vsetvl, commits vl/vtype
// and serves CSR reads. Optional vstart register under VEC_CSR_VSTART_EN.
module vec_csr_cfg
   import vec_csr_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int VLEN = 512,
   parameter int ELEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [1:0]      cfg_type,
   input  logic [XLEN-1:0] scalar1,
   input  logic [XLEN-1:0] scalar2,
   input  logic            rs1_is_x0,
   input  logic            rd_is_x0,
   output logic            rd_wb_valid,
   input  logic            rd_wb_ready,
   output logic [XLEN-1:0] rd_wb_data,
   output logic [XLEN-1:0] csr_vl,
   output logic [XLEN-1:0] csr_vtype,
   output logic [2:0]      vsew,
   output logic [2:0]      vlmul,
   output logic            vta,
   output logic            vma,
   output logic            vill,
   output logic            vl_change,
   input  logic            csr_rd_en,
   input  logic [11:0]     csr_rd_addr,
   output logic            csr_rd_valid,
   output logic [XLEN-1:0] csr_rd_data,
   output logic            csr_rd_err
`ifdef VEC_CSR_VSTART_EN
   ,
   input  logic            vstart_wr_en,
   input  logic [XLEN-1:0] vstart_wr_data
`endif
);

   localparam int VW  = $clog2(VLEN) + 1;
   localparam int VSW = $clog2(VLEN);
   localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state;
   cfg_type_e       type_q;
   logic [XLEN-1:0] avl_q;
   logic [XLEN-2:0] vtype_q;
   logic            rs1_x0_q;
   logic            rd_x0_q;

   logic [VW-1:0]   vlmax;
   logic            sew_lmul_ill;
   logic            vill_new;
   logic [XLEN-1:0] vlmax_x;
   logic [XLEN-1:0] vl_new;
   logic [XLEN-1:0] vtype_new;
   logic [XLEN-1:0] rd_data_next;
   logic            rd_err_next;
   logic            unused_bits;

   vec_vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN), .VW(VW)) u_vlmax (
      .vsew    (vtype_q[5:3]),
      .vlmul   (vtype_q[2:0]),
      .vlmax   (vlmax),
      .illegal (sew_lmul_ill)
   );

   always_comb begin
      vlmax_x   = XLEN'(vlmax);
      vill_new  = (|vtype_q[XLEN-2:8]) || sew_lmul_ill || (type_q == CFG_RSVD);
      vtype_new = {{(XLEN-8){1'b0}}, vtype_q[7:0]};
      // vsetivli always carries an explicit AVL; x0 forms either take VLMAX or keep vl
      if ((type_q == CFG_VSETIVLI) || !rs1_x0_q)
         vl_new = (avl_q < vlmax_x) ? avl_q : vlmax_x;
      else if (!rd_x0_q)
         vl_new = vlmax_x;
      else
         vl_new = (csr_vl < vlmax_x) ? csr_vl : vlmax_x;
      if (vill_new) begin
         vl_new    = '0;
         vtype_new = VTYPE_ILL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cfg_ready   <= 1'b1;
         rd_wb_valid <= 1'b0;
         rd_wb_data  <= '0;
         vl_change   <= 1'b0;
         csr_vl      <= '0;
         csr_vtype   <= VTYPE_ILL;
         type_q      <= CFG_VSETVLI;
         avl_q       <= '0;
         vtype_q     <= '0;
         rs1_x0_q    <= 1'b0;
         rd_x0_q     <= 1'b0;
      end else begin
         vl_change <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  type_q    <= cfg_type_e'(cfg_type);
                  avl_q     <= scalar1;
                  vtype_q   <= scalar2[XLEN-2:0];
                  rs1_x0_q  <= rs1_is_x0;
                  rd_x0_q   <= rd_is_x0;
                  cfg_ready <= 1'b0;
                  state     <= CALC;
               end
            end
            CALC: begin
               csr_vl      <= vl_new;
               csr_vtype   <= vtype_new;
               vl_change   <= 1'b1;
               rd_wb_valid <= 1'b1;
               rd_wb_data  <= vl_new;
               state       <= WB;
            end
            WB: begin
               if (rd_wb_ready) begin
                  rd_wb_valid <= 1'b0;
                  cfg_ready   <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign vsew  = csr_vtype[5:3];
   assign vlmul = csr_vtype[2:0];
   assign vta   = csr_vtype[6];
   assign vma   = csr_vtype[7];
   assign vill  = csr_vtype[XLEN-1];

`ifdef VEC_CSR_VSTART_EN
   logic [VSW-1:0] vstart;

   // A commit in CALC clears vstart and takes priority over a software write
   always_ff @(posedge clk) begin
      if (reset)
         vstart <= '0;
      else if (state == CALC)
         vstart <= '0;
      else if (vstart_wr_en)
         vstart <= vstart_wr_data[VSW-1:0];
   end

   assign unused_bits = ^{scalar2[XLEN-1], vstart_wr_data[XLEN-1:VSW]};
`else
   assign unused_bits = scalar2[XLEN-1];
`endif

   always_comb begin
      rd_data_next = '0;
      rd_err_next  = 1'b0;
      case (csr_rd_addr)
         CSR_ADDR_VL:     rd_data_next = csr_vl;
         CSR_ADDR_VTYPE:  rd_data_next = csr_vtype;
         CSR_ADDR_VLENB:  rd_data_next = XLEN'(VLEN / 8);
`ifdef VEC_CSR_VSTART_EN
         CSR_ADDR_VSTART: rd_data_next = XLEN'(vstart);
`else
         CSR_ADDR_VSTART: rd_err_next  = 1'b1;
`endif
         default:         rd_err_next  = 1'b1;
      endcase
   end

   // Reads sample the registers before any same-cycle commit lands
   always_ff @(posedge clk) begin
      if (reset) begin
         csr_rd_valid <= 1'b0;
         csr_rd_data  <= '0;
         csr_rd_err   <= 1'b0;
      end else begin
         csr_rd_valid <= csr_rd_en;
         csr_rd_data  <= csr_rd_en ? rd_data_next : '0;
         csr_rd_err   <= csr_rd_en ? rd_err_next : 1'b0;
      end
   end

endmodule
